alu_operand_stage: RTL
======================

# alu_operand_stage

Parametrised operand-select and pipeline-register stage between decode/register-read and the ALU. It selects ALU operands A and B from register data, PC, zero or immediate, and resolves RAW hazards by forwarding from FWD_CH later pipeline stages. It stalls on load-use hazards and registers the result behind a valid/ready handshake. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
- XLEN, 32, operand width
- REG_ADDR_W, 5, register index width
- FWD_CH, 2, number of forwarding channels; channel 0 is the youngest producer and has the highest priority
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- rs1_addr, rs2_addr  in  REG_ADDR_W  source register indices
- read_data1, read_data2  in  XLEN  register file data
- imm_data  in  XLEN  immediate
- pc  in  XLEN  instruction address
- a_sel  in  2  operand A source: 0 = rs1, 1 = pc, 2 = zero, 3 = zero
- imm_data_select  in  1  operand B source: 0 = rs2, 1 = imm_data
- uses_rs2  in  1  rs2 is needed as store data even when imm_data_select = 1
- fwd_valid  in  FWD_CH  channel holds a register-writing instruction
- fwd_pending  in  FWD_CH  channel result is not yet available (load in flight)
- fwd_rd_addr  in  FWD_CH*REG_ADDR_W  destination indices; channel k occupies bits [k*REG_ADDR_W +: REG_ADDR_W]
- fwd_data  in  FWD_CH*XLEN  channel results, packed the same way
- out_valid  out  1  registered operands are valid
- out_ready  in  1  ALU consumes the operands
- alu_input_a, alu_input_b  out  XLEN  registered operands
- store_data  out  XLEN  registered resolved rs2 value
- hazard_stall  out  1  a load-use hazard is blocking acceptance
- stall_cycles  out  16  saturating count of hazard_stall cycles

## Operation
- rs1 is used when a_sel = 0. rs2 is used when imm_data_select = 0 or uses_rs2 = 1.
- Resolved value of a source register:
  - index 0 resolves to 0, regardless of read_data or forwarding;
  - otherwise, the lowest-index channel k with fwd_valid[k] = 1 and fwd_rd_addr[k] equal to the source index supplies fwd_data[k];
  - otherwise, read_data1 or read_data2 supplies the value.
- Hazard condition: the matching winning channel for a used, nonzero source has fwd_pending = 1. Pending on a lower-priority matching channel is ignored, because the younger producer shadows it.
- hazard_stall = in_valid AND hazard.
- in_ready = (NOT out_valid OR out_ready) AND NOT hazard_stall. in_ready depends combinationally on out_ready.
- Accept occurs when in_valid AND in_ready. On accept, the output register loads:
  - alu_input_a = resolved rs1, pc, or 0 according to a_sel;
  - alu_input_b = resolved rs2 or imm_data according to imm_data_select;
  - store_data = resolved rs2;
  - out_valid is set to 1.
- When out_valid AND out_ready and there is no accept, out_valid is cleared to 0.
- When out_valid AND NOT out_ready, all outputs hold stable. Inputs may change freely during this time.
- stall_cycles increments in every cycle where hazard_stall = 1 and saturates at 16'hFFFF. It never wraps.

## Timing
- Reset (asynchronous on rst_n low) sets out_valid = 0, alu_input_a = 0, alu_input_b = 0, store_data = 0 and stall_cycles = 0. Any in-flight operand is discarded.
- After rst_n deasserts, the first accept is possible on the first rising edge.
- Latency is 1 cycle from accept edge to out_valid = 1. Throughput is 1 per cycle while out_ready = 1.
- When a pending channel clears, acceptance happens in the same cycle. No extra bubble is inserted beyond the stall cycles.
- When out_valid = 1 and out_ready = 1 and in_valid = 1 with no hazard, the stage drains and refills on the same edge. out_valid stays 1.
- A hazard with out_valid = 1 and out_ready = 1 drains the register and leaves out_valid = 0 (a bubble).
- hazard_stall is combinational. It is 0 whenever in_valid = 0.

## Configuration
- ALU_OPERAND_FWD_EN defined: forwarding, hazard detection and stall_cycles behave as described above.
- ALU_OPERAND_FWD_EN undefined:
  - all fwd_* inputs are ignored;
  - sources resolve to read_data1 or read_data2, with index 0 still resolving to 0;
  - hazard_stall is tied to 0 and stall_cycles is tied to 0;
  - the handshake and register behaviour are unchanged.

## Test plan
- Reset mid-transfer: out_valid = 1 and rst_n pulsed low for less than 1 cycle, between edges -> outputs are 0 immediately, and out_valid stays 0 until the next accept.
- No-hazard path: rs1 = 3, read_data1 = 0x11, a_sel = 0, imm_data_select = 1, imm_data = 0x20, out_ready = 1 -> one cycle later out_valid = 1, alu_input_a = 0x11, alu_input_b = 0x20.
- Forward priority: ch0 and ch1 both valid with rd = 5 (ch0 data 0xAA, ch1 data 0xBB), rs2 = 5 -> alu_input_b = 0xAA. With ch0 invalid -> alu_input_b = 0xBB. With rs2 = 0 -> alu_input_b = 0.
- Load-use stall: ch0 valid, rd = 7, pending for 3 cycles; rs1 = 7, a_sel = 0 -> hazard_stall = 1 for 3 cycles, stall_cycles = 3, accept on the 4th cycle with ch0 data. The same case with a_sel = 1 -> no stall.
- Backpressure: out_ready = 0 for 4 cycles while in_valid = 1 -> in_ready = 0 and outputs stable. When out_ready rises, drain and refill occur on the same edge with out_valid remaining 1.
- Saturation: hold a hazard for 65540 cycles -> stall_cycles = 0xFFFF and it does not wrap.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand select, forwarding and load-use stall ahead of the ALU.
// Build option: define ALU_OPERAND_FWD_EN to enable forwarding, hazards and stall counting.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_CH     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REG_ADDR_W-1:0]        rs1_addr,
  input  logic [REG_ADDR_W-1:0]        rs2_addr,
  input  logic [XLEN-1:0]              read_data1,
  input  logic [XLEN-1:0]              read_data2,
  input  logic [XLEN-1:0]              imm_data,
  input  logic [XLEN-1:0]              pc,
  input  logic [1:0]                   a_sel,
  input  logic                         imm_data_select,
  input  logic                         uses_rs2,
  input  logic [FWD_CH-1:0]            fwd_valid,
  input  logic [FWD_CH-1:0]            fwd_pending,
  input  logic [FWD_CH*REG_ADDR_W-1:0] fwd_rd_addr,
  input  logic [FWD_CH*XLEN-1:0]       fwd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              alu_input_a,
  output logic [XLEN-1:0]              alu_input_b,
  output logic [XLEN-1:0]              store_data,
  output logic                         hazard_stall,
  output logic [15:0]                  stall_cycles
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            hazard;
  logic            accept;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] sd_q, sd_d;

  // Resolve sources; scanning high to low lets the youngest channel win.
  always_comb begin
    rs1_val  = read_data1;
    rs2_val  = read_data2;
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
    for (int k = FWD_CH-1; k >= 0; k--) begin
      if (fwd_valid[k] &&
          fwd_rd_addr[k*REG_ADDR_W +: REG_ADDR_W] == rs1_addr) begin
        rs1_val  = fwd_data[k*XLEN +: XLEN];
        rs1_pend = fwd_pending[k];
      end
      if (fwd_valid[k] &&
          fwd_rd_addr[k*REG_ADDR_W +: REG_ADDR_W] == rs2_addr) begin
        rs2_val  = fwd_data[k*XLEN +: XLEN];
        rs2_pend = fwd_pending[k];
      end
    end
`endif
    if (rs1_addr == '0) begin
      rs1_val  = '0;
      rs1_pend = 1'b0;
    end
    if (rs2_addr == '0) begin
      rs2_val  = '0;
      rs2_pend = 1'b0;
    end
  end

`ifdef ALU_OPERAND_FWD_EN
  logic [15:0] stall_q, stall_d;

  assign hazard = ((a_sel == 2'd0) && rs1_pend) ||
                  ((!imm_data_select || uses_rs2) && rs2_pend);

  // Saturating count of cycles lost to load-use hazards.
  always_comb begin
    stall_d = stall_q;
    if (hazard_stall && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_pending, fwd_rd_addr,
                        fwd_data, uses_rs2, rs1_pend, rs2_pend};
  assign hazard       = 1'b0;
  assign stall_cycles = 16'd0;
`endif

  assign hazard_stall = in_valid && hazard;
  assign in_ready     = (!valid_q || out_ready) && !hazard_stall;
  assign accept       = in_valid && in_ready;

  // Output register: load on accept, drop valid when drained.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    sd_d    = sd_q;
    if (accept) begin
      valid_d = 1'b1;
      unique case (a_sel)
        2'd0:    a_d = rs1_val;
        2'd1:    a_d = pc;
        default: a_d = '0;
      endcase
      b_d  = imm_data_select ? imm_data : rs2_val;
      sd_d = rs2_val;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sd_q    <= sd_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_input_a = a_q;
  assign alu_input_b = b_q;
  assign store_data  = sd_q;

endmodule
